// File: rtl/sonic_tx_gearbox_66_40.sv
// Tx gearbox: pulls 66-bit {data,sync} blocks from the Tx ring and serialises them
// LSB-first into 40-bit PMA words (20 blocks map onto exactly 33 words).
module sonic_tx_gearbox_66_40 #(
  parameter int RD_LATENCY = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        tx_ready,
  input  logic [65:0] data_in,
  output logic        rdreq,
  output logic        rdena,
  output logic [39:0] data_out,
  output logic        data_valid,
  output logic        underflow
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int OUT_W = 40;
  localparam int BLK_W = 66;
  localparam int ACC_W = 106;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [6:0]            accCnt_q, accCnt_d;
  logic [BLK_W-1:0]      fifoMem_q [SKID_DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]      fifoCnt_q, fifoCnt_d;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic                  rdreq_q, rdreq_d;
  logic                  rdena_q;
  logic                  dataValid_q;
  logic                  underflow_q;
  logic [OUT_W-1:0]      dataOut_q;

  logic                  flush;
  logic                  emit;
  logic                  fifoWr;
  logic                  fifoPop;
  logic                  starved;
  logic [6:0]            rem;
  logic [31:0]           pending;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Dropping ena always wins, even over the PRIME->RUN promotion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ena) state_d = PRIME;
      PRIME: begin
        if (!ena)                    state_d = IDLE;
        else if (accCnt_q >= 7'd40)  state_d = RUN;
      end
      RUN:     if (!ena) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush   = (state_d == IDLE);
    emit    = (state_q == RUN) && tx_ready && (accCnt_q >= 7'd40) && !flush;
    starved = (state_q == RUN) && tx_ready && (accCnt_q < 7'd40) && !flush;
    rem     = emit ? (accCnt_q - 7'd40) : accCnt_q;
    fifoWr  = inflight_q[RD_LATENCY-1] && (state_q != IDLE) && !flush;
    fifoPop = (state_q != IDLE) && !flush && (rem < 7'd40) && (fifoCnt_q != '0);

    // Every request still in the ring pipeline already owns a skid slot.
    pending = 32'(fifoCnt_q) + 32'(rdreq_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      pending = pending + 32'(inflight_q[i]);
    end
    rdreq_d = !flush && ena && (pending < 32'(SKID_DEPTH));

    inflight_d    = inflight_q << 1;
    inflight_d[0] = rdreq_q;

    acc_d    = emit ? (acc_q >> OUT_W) : acc_q;
    accCnt_d = rem;
    if (fifoPop) begin
      acc_d    = acc_d | ({{(ACC_W - BLK_W){1'b0}}, fifoMem_q[rdPtr_q]} << rem);
      accCnt_d = rem + 7'd66;
    end

    fifoCnt_d = fifoCnt_q + CNT_W'(fifoWr) - CNT_W'(fifoPop);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rdreq_q     <= 1'b0;
      rdena_q     <= 1'b0;
      dataValid_q <= 1'b0;
      underflow_q <= 1'b0;
      dataOut_q   <= '0;
      acc_q       <= '0;
      accCnt_q    <= '0;
      fifoCnt_q   <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      rdreq_q     <= rdreq_d;
      rdena_q     <= (state_d != IDLE);
      dataValid_q <= emit;
      underflow_q <= starved;
      if (emit) dataOut_q <= acc_q[OUT_W-1:0];
      if (flush) begin
        acc_q      <= '0;
        accCnt_q   <= '0;
        fifoCnt_q  <= '0;
        wrPtr_q    <= '0;
        rdPtr_q    <= '0;
        inflight_q <= '0;
      end else begin
        acc_q      <= acc_d;
        accCnt_q   <= accCnt_d;
        fifoCnt_q  <= fifoCnt_d;
        inflight_q <= inflight_d;
        if (fifoWr)  wrPtr_q <= ptrInc(wrPtr_q);
        if (fifoPop) rdPtr_q <= ptrInc(rdPtr_q);
      end
    end
  end

  // Credit scheme above makes a write into a full skid buffer impossible.
  always_ff @(posedge clk_in) begin
    if (fifoWr) fifoMem_q[wrPtr_q] <= data_in;
    if (reset_n) assert (!(fifoWr && !fifoPop && (fifoCnt_q == CNT_W'(SKID_DEPTH))));
  end

  assign rdreq      = rdreq_q;
  assign rdena      = rdena_q;
  assign data_out   = dataOut_q;
  assign data_valid = dataValid_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_sonic_tx_gearbox_66_40.sv
// Bench for sonic_tx_gearbox_66_40: three instances (RD_LATENCY 1/2/3) fed by a ring model,
// every emitted word compared against the LSB-first bit serialisation of the ring's blocks.
module tb_sonic_tx_gearbox_66_40;

  localparam int N = 3;
  localparam int MAIN = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ena;
  logic        tx_ready;
  logic [65:0] dataIn [N];
  logic        rdreq  [N];
  logic        rdena  [N];
  logic        dv     [N];
  logic        uf     [N];
  logic [39:0] dout   [N];

  sonic_tx_gearbox_66_40 #(.RD_LATENCY(1), .SKID_DEPTH(4)) dutL1 (
    .clk_in(clk), .reset_n(reset_n), .ena(ena), .tx_ready(tx_ready), .data_in(dataIn[0]),
    .rdreq(rdreq[0]), .rdena(rdena[0]), .data_out(dout[0]), .data_valid(dv[0]), .underflow(uf[0]));
  sonic_tx_gearbox_66_40 #(.RD_LATENCY(2), .SKID_DEPTH(4)) dutL2 (
    .clk_in(clk), .reset_n(reset_n), .ena(ena), .tx_ready(tx_ready), .data_in(dataIn[1]),
    .rdreq(rdreq[1]), .rdena(rdena[1]), .data_out(dout[1]), .data_valid(dv[1]), .underflow(uf[1]));
  sonic_tx_gearbox_66_40 #(.RD_LATENCY(3), .SKID_DEPTH(4)) dutL3 (
    .clk_in(clk), .reset_n(reset_n), .ena(ena), .tx_ready(tx_ready), .data_in(dataIn[2]),
    .rdreq(rdreq[2]), .rdena(rdena[2]), .data_out(dout[2]), .data_valid(dv[2]), .underflow(uf[2]));

  // Ring model: k-th request returns {k,2'b01} exactly RD_LATENCY cycles later, garbage otherwise.
  logic [63:0] ringCnt [N]    = '{default: '0};
  logic [63:0] pipeIdx [N][4] = '{default: '0};
  logic        pipeVal [N][4] = '{default: 1'b0};
  logic [65:0] garbage        = '0;

  always @(posedge clk) begin
    garbage <= {$urandom, $urandom, 2'($urandom)};
    for (int d = 0; d < N; d++) begin
      for (int s = 3; s > 0; s--) begin
        pipeIdx[d][s] <= pipeIdx[d][s-1];
        pipeVal[d][s] <= pipeVal[d][s-1];
      end
      pipeIdx[d][0] <= ringCnt[d];
      pipeVal[d][0] <= rdreq[d];
      if (rdreq[d]) ringCnt[d] <= ringCnt[d] + 64'd1;
    end
  end

  always_comb begin
    for (int d = 0; d < N; d++) begin
      dataIn[d] = pipeVal[d][d] ? {pipeIdx[d][d], 2'b01} : garbage;
    end
  end

  int              checkCount = 0;
  int              passCount  = 0;
  int              failCount  = 0;
  logic [39:0]     wordsQ [N][$];
  longint unsigned startBlk [N];
  longint unsigned wordIdx  [N];
  int              ufCount  [N];
  int              reqSeen  [N];
  int              firstValid [N];

  // Bit p of a stream starting at block s is bit p%66 of block s+p/66.
  function automatic logic [39:0] expWord(input longint unsigned s, input longint unsigned j);
    logic [39:0]     w;
    logic [65:0]     blk;
    longint unsigned pos;
    for (int b = 0; b < 40; b++) begin
      pos  = 40 * j + longint'(b);
      blk  = {64'(s + pos / 66), 2'b01};
      w[b] = blk[int'(pos % 66)];
    end
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic enaV, input logic rdyV);
    ena      = enaV;
    tx_ready = rdyV;
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        if (dv[d])    wordsQ[d].push_back(dout[d]);
        if (uf[d])    ufCount[d]++;
        if (rdreq[d]) reqSeen[d]++;
      end
    end
  endtask

  task automatic drainStream(input string tag);
    logic [39:0] w;
    for (int d = 0; d < N; d++) begin
      while (wordsQ[d].size() > 0) begin
        w = wordsQ[d].pop_front();
        checkOutput($sformatf("%s.L%0d.w%0d", tag, d + 1, wordIdx[d]), 64'(w),
                    64'(expWord(startBlk[d], wordIdx[d])));
        wordIdx[d]++;
      end
    end
  endtask

  task automatic restartModel();
    for (int d = 0; d < N; d++) begin
      startBlk[d] = ringCnt[d];
      wordIdx[d]  = 0;
      wordsQ[d].delete();
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < N; d++) begin
      checkOutput($sformatf("%s.L%0d.rdreq", tag, d + 1), 64'(rdreq[d]), 64'd0);
      checkOutput($sformatf("%s.L%0d.rdena", tag, d + 1), 64'(rdena[d]), 64'd0);
      checkOutput($sformatf("%s.L%0d.dout", tag, d + 1), 64'(dout[d]), 64'd0);
      checkOutput($sformatf("%s.L%0d.valid", tag, d + 1), 64'(dv[d]), 64'd0);
      checkOutput($sformatf("%s.L%0d.uflow", tag, d + 1), 64'(uf[d]), 64'd0);
    end
  endtask

  // Called with ena about to be sampled 1 at the next rising edge.
  task automatic checkStartup(input string tag);
    for (int d = 0; d < N; d++) firstValid[d] = -1;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (k == 0) begin
        for (int d = 0; d < N; d++) begin
          checkOutput($sformatf("%s.L%0d.firstReq", tag, d + 1), 64'(rdreq[d]), 64'd1);
          checkOutput($sformatf("%s.L%0d.rdena", tag, d + 1), 64'(rdena[d]), 64'd1);
        end
      end
      for (int d = 0; d < N; d++) begin
        if (firstValid[d] < 0 && dv[d]) firstValid[d] = k;
      end
    end
    for (int d = 0; d < N; d++) begin
      checkOutput($sformatf("%s.L%0d.latency(%0d)", tag, d + 1, firstValid[d]),
                  64'(firstValid[d] >= 0 && firstValid[d] <= d + 5), 64'd1);
      if (wordsQ[d].size() > 0)
        checkOutput($sformatf("%s.L%0d.firstSync", tag, d + 1), 64'(wordsQ[d][0][1:0]), 64'd1);
      else
        checkOutput($sformatf("%s.L%0d.firstWordSeen", tag, d + 1), 64'd0, 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint unsigned heldIdx [N];
    for (int d = 0; d < N; d++) begin
      ufCount[d] = 0;
      reqSeen[d] = 0;
    end
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick(2);
    checkAllZero("reset");
    reset_n = 1'b1;
    tick(3);
    checkAllZero("idle");

    // Startup from IDLE with full-rate PMA.
    restartModel();
    applyStimulus(1'b1, 1'b1);
    checkStartup("startup");
    tick(40);
    drainStream("stream1");

    // Steady state: a word every cycle, ~20 ring reads per 33 words.
    for (int d = 0; d < N; d++) reqSeen[d] = 0;
    tick(165);
    for (int d = 0; d < N; d++) begin
      checkOutput($sformatf("rate.L%0d.words", d + 1), 64'(wordsQ[d].size()), 64'd165);
      checkOutput($sformatf("rate.L%0d.reqs(%0d)", d + 1, reqSeen[d]),
                  64'(reqSeen[d] >= 94 && reqSeen[d] <= 106), 64'd1);
    end
    drainStream("stream2");

    // PMA back-pressure for 6 cycles.
    tick(3);
    for (int d = 0; d < N; d++) heldIdx[d] = wordIdx[d] + longint'(wordsQ[d].size()) - 1;
    applyStimulus(1'b1, 1'b0);
    for (int s = 1; s <= 6; s++) begin
      tick(1);
      for (int d = 0; d < N; d++) begin
        checkOutput($sformatf("stall%0d.L%0d.valid", s, d + 1), 64'(dv[d]), 64'd0);
        checkOutput($sformatf("stall%0d.L%0d.hold", s, d + 1), 64'(dout[d]),
                    64'(expWord(startBlk[d], heldIdx[d])));
        if (s == 6)
          checkOutput($sformatf("stall.L%0d.rdreqStop", d + 1), 64'(rdreq[d]), 64'd0);
      end
    end
    applyStimulus(1'b1, 1'b1);
    tick(40);
    drainStream("resume");

    // Drop ena mid-stream, then re-enable on a fresh block boundary.
    tick(10);
    drainStream("preDrop");
    applyStimulus(1'b0, 1'b1);
    tick(1);
    for (int d = 0; d < N; d++) begin
      checkOutput($sformatf("drop.L%0d.rdreq", d + 1), 64'(rdreq[d]), 64'd0);
      checkOutput($sformatf("drop.L%0d.rdena", d + 1), 64'(rdena[d]), 64'd0);
      checkOutput($sformatf("drop.L%0d.valid", d + 1), 64'(dv[d]), 64'd0);
    end
    tick(8);
    for (int d = 0; d < N; d++)
      checkOutput($sformatf("idle.L%0d.noWords", d + 1), 64'(wordsQ[d].size()), 64'd0);
    restartModel();
    applyStimulus(1'b1, 1'b1);
    checkStartup("reenable");
    tick(50);
    drainStream("stream3");

    // Asynchronous reset between edges while running.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 checkAllZero("asyncReset");
    tick(3);
    checkAllZero("inReset");
    drainStream("postReset");
    restartModel();
    reset_n = 1'b1;
    checkStartup("recover");
    tick(50);
    drainStream("stream4");

    // Random PMA back-pressure across all three latencies.
    for (int c = 0; c < 800; c++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 3) != 0));
      tick(1);
    end
    applyStimulus(1'b1, 1'b1);
    tick(20);
    drainStream("random");
    for (int d = 0; d < N; d++)
      checkOutput($sformatf("underflow.L%0d", d + 1), 64'(ufCount[d]), 64'd0);
    checkOutput("mainWordsTotal", 64'(wordIdx[MAIN] > 600), 64'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
